tern_gate_checker: RTL and testbench

Synthesizable self-test engine for two-input ternary gates using the 2-bit trit encoding: 2'b00 = 0, 2'b01 = 1, 2'b10 = 2, 2'b11 = illegal. It is the checking counterpart of the gate stimulus bench. On `start` it sweeps all nine (A, B) trit pairs into a gate under test, samples the gate output after a programmable settle time, and compares it against a built-in ternary NOR model. It reports a mismatch count, the first failing vector and a pass/fail result, so gate checks can run on-chip or in a plain clocked simulation.

---
 rtl/tern_gate_checker_if.sv | 45 ++++
 rtl/tern_gate_checker.sv | 165 ++++++++++++++++
 tb/tb_tern_gate_checker.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tern_gate_checker_if.sv
// tern_gate_checker_if: start/result handshake plus the
// A/B/C trit bus between the checker and the gate under test.
interface tern_gate_checker_if #(
  parameter int ERR_W = 4
);
  logic             start;
  logic [1:0]       a_out;
  logic [1:0]       b_out;
  logic [1:0]       c_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       first_err_idx;
  logic [1:0]       first_err_c;
  logic             illegal;

  modport slave (
    input  start,
    input  c_in,
    output a_out,
    output b_out,
    output busy,
    output done,
    output pass,
    output err_count,
    output first_err_idx,
    output first_err_c,
    output illegal
  );

  modport master (
    output start,
    output c_in,
    input  a_out,
    input  b_out,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  first_err_idx,
    input  first_err_c,
    input  illegal
  );
endinterface

// File: rtl/tern_gate_checker.sv
// tern_gate_checker: sweeps all nine trit pairs into a gate
// and checks its output against ternary NOR, exp = 2 - max(A,B).
module tern_gate_checker #(
  parameter int SETTLE = 1,
  parameter int ERR_W  = 4
) (
  input logic                clk,
  input logic                rst,
  tern_gate_checker_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0]       LP_SET = 4'(SETTLE);
  localparam logic [ERR_W-1:0] LP_SAT = '1;

  state_t           r_state;
  logic [3:0]       r_k;
  logic [3:0]       r_cnt;
  logic [1:0]       r_a;
  logic [1:0]       r_b;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [3:0]       r_fidx;
  logic [1:0]       r_fc;
  logic             r_ill;

  state_t           w_state;
  logic [3:0]       w_k;
  logic [3:0]       w_cnt;
  logic [1:0]       w_a;
  logic [1:0]       w_b;
  logic             w_busy;
  logic             w_done;
  logic             w_pass;
  logic [ERR_W-1:0] w_err;
  logic [3:0]       w_fidx;
  logic [1:0]       w_fc;
  logic             w_ill;

  logic [1:0]       w_max;
  logic [1:0]       w_exp;
  logic             w_mism;
  logic [ERR_W-1:0] w_err_upd;

  always_comb begin
    w_max  = (r_a > r_b) ? r_a : r_b;
    w_exp  = 2'd2 - w_max;
    // 2'b11 can never equal w_exp, so it always mismatches
    w_mism = (bus.c_in != w_exp);
    w_err_upd = r_err;
    if (w_mism && (r_err != LP_SAT))
      w_err_upd = r_err + 1'b1;

    w_state = r_state;
    w_k     = r_k;
    w_cnt   = r_cnt;
    w_a     = r_a;
    w_b     = r_b;
    w_busy  = r_busy;
    w_done  = r_done;
    w_pass  = r_pass;
    w_err   = r_err;
    w_fidx  = r_fidx;
    w_fc    = r_fc;
    w_ill   = r_ill;

    unique case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_state = APPLY;
          w_k     = 4'd0;
          w_cnt   = LP_SET;
          w_a     = 2'd0;
          w_b     = 2'd0;
          w_busy  = 1'b1;
          w_done  = 1'b0;
          w_pass  = 1'b0;
          w_err   = '0;
          w_fidx  = 4'hF;
          w_fc    = 2'd0;
          w_ill   = 1'b0;
        end
      end
      APPLY: begin
        if (r_cnt != 4'd0) begin
          w_cnt = r_cnt - 4'd1;
        end else begin
          w_err = w_err_upd;
          if (w_mism && (r_fidx == 4'hF)) begin
            w_fidx = r_k;
            w_fc   = bus.c_in;
          end
          if (bus.c_in == 2'b11)
            w_ill = 1'b1;
          if (r_k == 4'd8) begin
            w_state = DONE;
            w_a     = 2'd0;
            w_b     = 2'd0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_pass  = (w_err_upd == '0);
          end else begin
            w_k   = r_k + 4'd1;
            w_cnt = LP_SET;
            if (r_b == 2'd2) begin
              w_b = 2'd0;
              w_a = r_a + 2'd1;
            end else begin
              w_b = r_b + 2'd1;
            end
          end
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= 4'd0;
      r_cnt   <= 4'd0;
      r_a     <= 2'd0;
      r_b     <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fidx  <= 4'hF;
      r_fc    <= 2'd0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_k     <= w_k;
      r_cnt   <= w_cnt;
      r_a     <= w_a;
      r_b     <= w_b;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_pass  <= w_pass;
      r_err   <= w_err;
      r_fidx  <= w_fidx;
      r_fc    <= w_fc;
      r_ill   <= w_ill;
    end
  end

  assign bus.a_out         = r_a;
  assign bus.b_out         = r_b;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.pass          = r_pass;
  assign bus.err_count     = r_err;
  assign bus.first_err_idx = r_fidx;
  assign bus.first_err_c   = r_fc;
  assign bus.illegal       = r_ill;
endmodule

// File: tb/tb_tern_gate_checker.sv
// tb_tern_gate_checker: three checkers (SETTLE 1/0/2) share one
// table-driven fake gate; results compared to tables and a model.
module tb_tern_gate_checker;
  typedef logic [8:0][1:0] tab_t;

  typedef struct {
    string nm;
    tab_t  tab;
    int    e_cnt;
    int    e_idx;
    int    e_c;
    int    e_ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  tab_t gate_tab = '0;

  int n_tot = 0;
  int n_pass = 0;

  logic [31:0] s_a[3];
  logic [31:0] s_b[3];
  logic [31:0] s_busy[3];
  logic [31:0] s_done[3];
  logic [31:0] s_pass[3];
  logic [31:0] s_err[3];
  logic [31:0] s_fidx[3];
  logic [31:0] s_fc[3];
  logic [31:0] s_ill[3];

  int set_v[3] = '{1, 0, 2};
  int errw_v[3] = '{4, 2, 4};

  always #5 clk = ~clk;

  tern_gate_checker_if #(.ERR_W(4)) if0 ();
  tern_gate_checker_if #(.ERR_W(2)) if1 ();
  tern_gate_checker_if #(.ERR_W(4)) if2 ();

  tern_gate_checker #(.SETTLE(1), .ERR_W(4)) u0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  tern_gate_checker #(.SETTLE(0), .ERR_W(2)) u1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  tern_gate_checker #(.SETTLE(2), .ERR_W(4)) u2 (
    .clk(clk), .rst(rst), .bus(if2)
  );

  function automatic int gi(logic [1:0] a, logic [1:0] b);
    return int'(a) * 3 + int'(b);
  endfunction

  assign if0.start = start;
  assign if1.start = start;
  assign if2.start = start;
  always_comb if0.c_in = gate_tab[gi(if0.a_out, if0.b_out)];
  always_comb if1.c_in = gate_tab[gi(if1.a_out, if1.b_out)];
  always_comb if2.c_in = gate_tab[gi(if2.a_out, if2.b_out)];

  task automatic snap();
    s_a[0] = 32'(if0.a_out);   s_b[0] = 32'(if0.b_out);
    s_a[1] = 32'(if1.a_out);   s_b[1] = 32'(if1.b_out);
    s_a[2] = 32'(if2.a_out);   s_b[2] = 32'(if2.b_out);
    s_busy[0] = 32'(if0.busy); s_done[0] = 32'(if0.done);
    s_busy[1] = 32'(if1.busy); s_done[1] = 32'(if1.done);
    s_busy[2] = 32'(if2.busy); s_done[2] = 32'(if2.done);
    s_pass[0] = 32'(if0.pass); s_err[0] = 32'(if0.err_count);
    s_pass[1] = 32'(if1.pass); s_err[1] = 32'(if1.err_count);
    s_pass[2] = 32'(if2.pass); s_err[2] = 32'(if2.err_count);
    s_fidx[0] = 32'(if0.first_err_idx);
    s_fidx[1] = 32'(if1.first_err_idx);
    s_fidx[2] = 32'(if2.first_err_idx);
    s_fc[0] = 32'(if0.first_err_c); s_ill[0] = 32'(if0.illegal);
    s_fc[1] = 32'(if1.first_err_c); s_ill[1] = 32'(if1.illegal);
    s_fc[2] = 32'(if2.first_err_c); s_ill[2] = 32'(if2.illegal);
  endtask

  task automatic chk(string nm, int i, logic [31:0] act,
                     logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s[u%0d]: got %0h want %0h", nm, i, act, exp);
    else
      n_pass++;
  endtask

  // Reference: walk the nine vectors straight from the NOR rule.
  task automatic model(input tab_t t, input int w,
                       output int cnt, output int fi,
                       output int fc, output int il);
    int a, b, e, v;
    cnt = 0; fi = 15; fc = 0; il = 0;
    for (int k = 0; k < 9; k++) begin
      a = k / 3;
      b = k % 3;
      e = 2 - ((a > b) ? a : b);
      v = int'(t[k]);
      if (v != e) begin
        if (cnt < (1 << w) - 1) cnt++;
        if (fi == 15) begin
          fi = k;
          fc = v;
        end
      end
      if (v == 3) il = 1;
    end
  endtask

  task automatic chk_reset_vals(string nm);
    for (int i = 0; i < 3; i++) begin
      chk({nm, ".a"}, i, s_a[i], 0);
      chk({nm, ".b"}, i, s_b[i], 0);
      chk({nm, ".busy"}, i, s_busy[i], 0);
      chk({nm, ".done"}, i, s_done[i], 0);
      chk({nm, ".pass"}, i, s_pass[i], 0);
      chk({nm, ".err"}, i, s_err[i], 0);
      chk({nm, ".fidx"}, i, s_fidx[i], 32'hF);
      chk({nm, ".fc"}, i, s_fc[i], 0);
      chk({nm, ".ill"}, i, s_ill[i], 0);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // One sweep: per-cycle timing/vector checks, then final results.
  task automatic sweep(input tab_t t, input string nm);
    int s, l, ke, cnt, fi, fc, il;
    gate_tab = t;
    pulse_start();
    for (int n = 0; n < 28; n++) begin
      @(negedge clk);
      snap();
      for (int i = 0; i < 3; i++) begin
        s = set_v[i] + 1;
        l = 9 * s;
        ke = (n < l) ? n / s : 0;
        chk({nm, ".busy"}, i, s_busy[i], (n < l) ? 1 : 0);
        chk({nm, ".done"}, i, s_done[i], (n >= l) ? 1 : 0);
        chk({nm, ".a"}, i, s_a[i], ke / 3);
        chk({nm, ".b"}, i, s_b[i], ke % 3);
      end
    end
    for (int i = 0; i < 3; i++) begin
      model(t, errw_v[i], cnt, fi, fc, il);
      chk({nm, ".err"}, i, s_err[i], cnt);
      chk({nm, ".fidx"}, i, s_fidx[i], fi);
      chk({nm, ".fc"}, i, s_fc[i], fc);
      chk({nm, ".ill"}, i, s_ill[i], il);
      chk({nm, ".pass"}, i, s_pass[i], (cnt == 0) ? 1 : 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  vec_t vt[4];
  tab_t t_ok;
  tab_t t_rnd;

  initial begin
    t_ok = {2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2};
    vt[0] = '{"nor", t_ok, 0, 15, 0, 0};
    vt[1] = '{"st00", '0, 4, 0, 0, 0};
    vt[2] = '{"k5ill",
              {2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2},
              1, 5, 3, 1};
    vt[3] = '{"st11", '1, 9, 0, 3, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    snap();
    chk_reset_vals("rst");
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      sweep(vt[v].tab, vt[v].nm);
      chk({vt[v].nm, ".t_err"}, 0, s_err[0], vt[v].e_cnt);
      chk({vt[v].nm, ".t_idx"}, 0, s_fidx[0], vt[v].e_idx);
      chk({vt[v].nm, ".t_c"}, 0, s_fc[0], vt[v].e_c);
      chk({vt[v].nm, ".t_ill"}, 0, s_ill[0], vt[v].e_ill);
      chk({vt[v].nm, ".t_pass"}, 0, s_pass[0],
          (vt[v].e_cnt == 0) ? 1 : 0);
    end
    chk("st11.sat", 1, s_err[1], 3);

    for (int r = 0; r < 6; r++) begin
      t_rnd = t_ok;
      for (int k = 0; k < 9; k++)
        if ($urandom_range(0, 2) == 0)
          t_rnd[k] = 2'($urandom_range(0, 3));
      sweep(t_rnd, "rnd");
    end

    // Reset while u0 is on vector 4, then a clean sweep.
    gate_tab = t_ok;
    pulse_start();
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    snap();
    chk_reset_vals("midrst");
    rst = 1'b0;
    sweep(t_ok, "after");

    // Level-held start on a faulty gate: done for one cycle only.
    do_reset();
    gate_tab = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      snap();
      chk("hold.done", 0, s_done[0], (n == 18) ? 1 : 0);
      chk("hold.busy", 0, s_busy[0], (n == 18) ? 0 : 1);
      if (n == 18) begin
        chk("hold.err18", 0, s_err[0], 4);
        chk("hold.pass18", 0, s_pass[0], 0);
      end
      if (n == 19) begin
        chk("hold.err19", 0, s_err[0], 0);
        chk("hold.fidx19", 0, s_fidx[0], 32'hF);
        chk("hold.a19", 0, s_a[0], 0);
        chk("hold.b19", 0, s_b[0], 0);
      end
    end
    start = 1'b0;
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
